// File: rtl/fmv_frame_scheduler_pkg.sv
// Shared FMV types: the planar YUV frame address set passed between decoder,
// allocator and display, plus the repeat-count load helper.
package fmv_frame_scheduler_pkg;

    typedef struct packed {
        logic [31:0] y_addr;
        logic [31:0] u_addr;
        logic [31:0] v_addr;
    } planar_yuv_s;

    // A repeat count of zero behaves like one: every vsync may change frame.
    function automatic logic [3:0] rep_load(input logic [3:0] rc);
        return (rc == 4'd0) ? 4'd1 : rc;
    endfunction

endpackage

// File: rtl/fmv_frame_scheduler.sv
// Display-side FMV frame scheduler: pops decoded frames from the address FIFO
// on vsync, repeats them for rate conversion, and returns superseded frames.
module fmv_frame_scheduler
    import fmv_frame_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_valid,
    input  planar_yuv_s      fifo_q,
    output logic             fifo_strobe,
    input  logic             vsync,
    input  logic             enable,
    input  logic [3:0]       repeat_count,
    input  logic             flush,
    output planar_yuv_s      show_frame,
    output logic             show_valid,
    output planar_yuv_s      release_frame,
    output logic             release_strobe,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        EMPTY,
        SHOWING
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       rem_q, rem_d;
    logic [1:0]       settle_q, settle_d;
    logic             strobe_q, strobe_d;
    logic             pop_rel_q, pop_rel_d;
    logic             flush_pend_q, flush_pend_d;
    planar_yuv_s      show_q, show_d;
    planar_yuv_s      rel_q, rel_d;
    logic             show_valid_q, show_valid_d;
    logic             rel_strobe_q, rel_strobe_d;
    logic [CNT_W-1:0] under_q, under_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             ready;
    logic             do_flush;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        strobe_d     = 1'b0;
        pop_rel_d    = 1'b0;
        flush_pend_d = 1'b0;
        show_d       = show_q;
        rel_d        = rel_q;
        show_valid_d = show_valid_q;
        rel_strobe_d = 1'b0;
        under_d      = under_q;
        frame_d      = frame_q;
        settle_d     = strobe_q ? 2'd2 : ((settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0);

        ready    = fifo_valid && enable && (settle_q == 2'd0);
        // A flush landing on the strobe cycle waits one cycle so the popped
        // frame is captured first and then released like any shown frame.
        do_flush = flush_pend_q || (flush && !strobe_q);

        if (strobe_q) begin
            show_d       = fifo_q;
            show_valid_d = 1'b1;
            state_d      = SHOWING;
            frame_d      = frame_q + CNT_W'(1);
            flush_pend_d = flush;
            if (pop_rel_q) begin
                rel_strobe_d = 1'b1;
                rel_d        = show_q;
            end
        end else if (do_flush) begin
            if (state_q == SHOWING) begin
                rel_strobe_d = 1'b1;
                rel_d        = show_q;
                show_valid_d = 1'b0;
                state_d      = EMPTY;
            end
        end else if (vsync) begin
            unique case (state_q)
                EMPTY: begin
                    if (ready) begin
                        strobe_d = 1'b1;
                        rem_d    = rep_load(repeat_count);
                    end
                end
                SHOWING: begin
                    if (rem_q > 4'd1) begin
                        rem_d = rem_q - 4'd1;
                    end else if (ready) begin
                        strobe_d  = 1'b1;
                        pop_rel_d = 1'b1;
                        rem_d     = rep_load(repeat_count);
                    end else if (enable && (under_q != '1)) begin
                        under_d = under_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            rem_q        <= '0;
            settle_q     <= '0;
            strobe_q     <= 1'b0;
            pop_rel_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            show_q       <= '0;
            rel_q        <= '0;
            show_valid_q <= 1'b0;
            rel_strobe_q <= 1'b0;
            under_q      <= '0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            settle_q     <= settle_d;
            strobe_q     <= strobe_d;
            pop_rel_q    <= pop_rel_d;
            flush_pend_q <= flush_pend_d;
            show_q       <= show_d;
            rel_q        <= rel_d;
            show_valid_q <= show_valid_d;
            rel_strobe_q <= rel_strobe_d;
            under_q      <= under_d;
            frame_q      <= frame_d;
        end
    end

    assign fifo_strobe    = strobe_q;
    assign show_frame     = show_q;
    assign show_valid     = show_valid_q;
    assign release_frame  = rel_q;
    assign release_strobe = rel_strobe_q;
    assign underrun_cnt   = under_q;
    assign frame_cnt      = frame_q;

endmodule

// File: tb/tb_fmv_frame_scheduler.sv
// Directed bench for fmv_frame_scheduler with a registered-output FIFO model.
module tb_fmv_frame_scheduler;
    import fmv_frame_scheduler_pkg::*;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_valid = 1'b0;
    planar_yuv_s   fifo_q = '0;
    logic          fifo_strobe;
    logic          vsync = 1'b0;
    logic          enable = 1'b1;
    logic [3:0]    repeat_count = 4'd1;
    logic          flush = 1'b0;
    planar_yuv_s   show_frame;
    logic          show_valid;
    planar_yuv_s   release_frame;
    logic          release_strobe;
    logic [CW-1:0] underrun_cnt;
    logic [CW-1:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    fmv_frame_scheduler #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_valid    (fifo_valid),
        .fifo_q        (fifo_q),
        .fifo_strobe   (fifo_strobe),
        .vsync         (vsync),
        .enable        (enable),
        .repeat_count  (repeat_count),
        .flush         (flush),
        .show_frame    (show_frame),
        .show_valid    (show_valid),
        .release_frame (release_frame),
        .release_strobe(release_strobe),
        .underrun_cnt  (underrun_cnt),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model with registered head/valid
    planar_yuv_s fq[$];
    always @(posedge clk) begin
        if (fifo_strobe === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        fifo_valid <= (fq.size() > 0);
        fifo_q     <= (fq.size() > 0) ? fq[0] : '0;
    end

    int n_strobe = 0;
    int n_rel = 0;
    always @(posedge clk) begin
        if (fifo_strobe === 1'b1) n_strobe++;
        if (release_strobe === 1'b1) n_rel++;
    end

    // observations from the last vsync window
    logic        o_strobe1, o_rel1, o_valid1;
    planar_yuv_s o_relf1;
    planar_yuv_s o_show2, o_relf2;
    logic        o_valid2, o_rel2;
    int          o_nstrobe, o_nrel;

    function automatic planar_yuv_s mk(input logic [7:0] n);
        planar_yuv_s f;
        f.y_addr = {n, 24'h100000};
        f.u_addr = {n, 24'h400000};
        f.v_addr = {n, 24'h500000};
        return f;
    endfunction

    task automatic push(input planar_yuv_s f);
        fq.push_back(f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        fq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pulse vsync (optionally with flush) at a negedge and observe an 8-cycle window.
    task automatic pulse_vsync(input bit with_flush);
        int s0, r0;
        s0 = n_strobe;
        r0 = n_rel;
        vsync = 1'b1;
        flush = with_flush;
        @(negedge clk);
        vsync = 1'b0;
        flush = 1'b0;
        o_strobe1 = fifo_strobe;
        o_rel1    = release_strobe;
        o_relf1   = release_frame;
        o_valid1  = show_valid;
        @(negedge clk);
        o_show2  = show_frame;
        o_valid2 = show_valid;
        o_rel2   = release_strobe;
        o_relf2  = release_frame;
        repeat (6) @(negedge clk);
        o_nstrobe = n_strobe - s0;
        o_nrel    = n_rel - r0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (fifo_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", fifo_strobe); end
        total++; if (show_valid !== 1'b0) begin bad++; $display("FAIL reset_show_valid: got %b want 0", show_valid); end
        total++; if (show_frame !== '0) begin bad++; $display("FAIL reset_show_frame: got %h want 0", show_frame); end
        total++; if (release_strobe !== 1'b0 || release_frame !== '0) begin bad++; $display("FAIL reset_release: got %b/%h want 0/0", release_strobe, release_frame); end
        total++; if (underrun_cnt !== '0 || frame_cnt !== '0) begin bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", underrun_cnt, frame_cnt); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_startup();
        planar_yuv_s exp_show [6];
        bit          exp_pop  [6];
        bit          exp_rel  [6];
        planar_yuv_s exp_relf [6];
        exp_show = '{mk(8'hA0), mk(8'hA0), mk(8'hB0), mk(8'hB0), mk(8'hC0), mk(8'hC0)};
        exp_pop  = '{1, 0, 1, 0, 1, 0};
        exp_rel  = '{0, 0, 1, 0, 1, 0};
        exp_relf = '{'0, '0, mk(8'hA0), '0, mk(8'hB0), '0};
        repeat_count = 4'd2;
        enable = 1'b1;
        push(mk(8'hA0)); push(mk(8'hB0)); push(mk(8'hC0));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            pulse_vsync(1'b0);
            total++; if (o_show2 !== exp_show[i] || o_valid2 !== 1'b1) begin bad++; $display("FAIL startup_show[%0d]: got %h/%b want %h/1", i, o_show2, o_valid2, exp_show[i]); end
            total++; if (o_strobe1 !== exp_pop[i] || o_nstrobe != int'(exp_pop[i])) begin bad++; $display("FAIL startup_pop[%0d]: got %b (n=%0d) want %b", i, o_strobe1, o_nstrobe, exp_pop[i]); end
            total++; if (o_rel2 !== exp_rel[i] || o_nrel != int'(exp_rel[i])) begin bad++; $display("FAIL startup_rel[%0d]: got %b (n=%0d) want %b", i, o_rel2, o_nrel, exp_rel[i]); end
            if (exp_rel[i]) begin
                total++; if (o_relf2 !== exp_relf[i]) begin bad++; $display("FAIL startup_relframe[%0d]: got %h want %h", i, o_relf2, exp_relf[i]); end
            end
        end
        total++; if (frame_cnt !== CW'(3) || underrun_cnt !== '0) begin bad++; $display("FAIL startup_counts: got %0d/%0d want 3/0", frame_cnt, underrun_cnt); end
    endtask

    task automatic test_underrun();
        do_reset();
        repeat_count = 4'd1;
        push(mk(8'hA1));
        repeat (2) @(negedge clk);
        pulse_vsync(1'b0);
        total++; if (o_show2 !== mk(8'hA1) || o_nrel != 0) begin bad++; $display("FAIL underrun_first: got %h rel=%0d want %h rel=0", o_show2, o_nrel, mk(8'hA1)); end
        for (int i = 1; i <= 3; i++) begin
            pulse_vsync(1'b0);
            total++; if (o_nstrobe != 0 || o_nrel != 0 || underrun_cnt !== CW'(i)) begin bad++; $display("FAIL underrun_count[%0d]: got cnt=%0d strobes=%0d rel=%0d want %0d/0/0", i, underrun_cnt, o_nstrobe, o_nrel, i); end
        end
        enable = 1'b0;
        pulse_vsync(1'b0);
        total++; if (underrun_cnt !== CW'(3) || o_nstrobe != 0) begin bad++; $display("FAIL underrun_disabled: got %0d/%0d want 3/0", underrun_cnt, o_nstrobe); end
        enable = 1'b1;
        push(mk(8'hB1));
        repeat (2) @(negedge clk);
        pulse_vsync(1'b0);
        total++; if (o_show2 !== mk(8'hB1) || o_rel2 !== 1'b1 || o_relf2 !== mk(8'hA1)) begin bad++; $display("FAIL underrun_recover: got %h rel=%b %h want %h rel=1 %h", o_show2, o_rel2, o_relf2, mk(8'hB1), mk(8'hA1)); end
        total++; if (frame_cnt !== CW'(2)) begin bad++; $display("FAIL underrun_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_repeat_zero();
        repeat_count = 4'd0;
        push(mk(8'hC2)); push(mk(8'hD2));
        repeat (2) @(negedge clk);
        pulse_vsync(1'b0);
        total++; if (o_show2 !== mk(8'hC2) || o_relf2 !== mk(8'hB1) || o_rel2 !== 1'b1) begin bad++; $display("FAIL rep0_first: got %h rel %h want %h rel %h", o_show2, o_relf2, mk(8'hC2), mk(8'hB1)); end
        pulse_vsync(1'b0);
        total++; if (o_show2 !== mk(8'hD2) || o_relf2 !== mk(8'hC2) || o_rel2 !== 1'b1) begin bad++; $display("FAIL rep0_second: got %h rel %h want %h rel %h", o_show2, o_relf2, mk(8'hD2), mk(8'hC2)); end
        pulse_vsync(1'b0);
        total++; if (underrun_cnt !== CW'(4) || frame_cnt !== CW'(4)) begin bad++; $display("FAIL rep0_counts: got %0d/%0d want 4/4", underrun_cnt, frame_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat_count = 4'd1;
        push(mk(8'hA3));
        repeat (2) @(negedge clk);
        pulse_vsync(1'b0);
        push(mk(8'hB3));
        repeat (2) @(negedge clk);
        pulse_vsync(1'b1);
        total++; if (o_rel1 !== 1'b1 || o_relf1 !== mk(8'hA3) || o_valid1 !== 1'b0) begin bad++; $display("FAIL flush_release: got rel=%b %h valid=%b want 1 %h 0", o_rel1, o_relf1, o_valid1, mk(8'hA3)); end
        total++; if (o_nstrobe != 0 || o_nrel != 1) begin bad++; $display("FAIL flush_no_pop: got strobes=%0d rels=%0d want 0/1", o_nstrobe, o_nrel); end
        pulse_vsync(1'b0);
        total++; if (o_show2 !== mk(8'hB3) || o_valid2 !== 1'b1 || o_nrel != 0) begin bad++; $display("FAIL flush_repop: got %h valid=%b rels=%0d want %h 1 0", o_show2, o_valid2, o_nrel, mk(8'hB3)); end
        // flush on the strobe cycle of a replacement pop
        push(mk(8'hC3));
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        flush = 1'b1;
        total++; if (fifo_strobe !== 1'b1) begin bad++; $display("FAIL flushpend_strobe: got %b want 1", fifo_strobe); end
        @(negedge clk);
        flush = 1'b0;
        total++; if (show_frame !== mk(8'hC3) || show_valid !== 1'b1 || release_strobe !== 1'b1 || release_frame !== mk(8'hB3)) begin bad++; $display("FAIL flushpend_t2: got %h v=%b rel=%b %h want %h 1 1 %h", show_frame, show_valid, release_strobe, release_frame, mk(8'hC3), mk(8'hB3)); end
        @(negedge clk);
        total++; if (release_strobe !== 1'b1 || release_frame !== mk(8'hC3) || show_valid !== 1'b0) begin bad++; $display("FAIL flushpend_t3: got rel=%b %h v=%b want 1 %h 0", release_strobe, release_frame, show_valid, mk(8'hC3)); end
        repeat (6) @(negedge clk);
        total++; if (frame_cnt !== CW'(3)) begin bad++; $display("FAIL flush_frame_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_reset_mid_pop();
        int r0;
        do_reset();
        repeat_count = 4'd1;
        push(mk(8'hA4));
        repeat (2) @(negedge clk);
        r0 = n_rel;
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        total++; if (fifo_strobe !== 1'b1) begin bad++; $display("FAIL midreset_strobe_before: got %b want 1", fifo_strobe); end
        #1 reset = 1'b1;
        #1;
        total++; if (fifo_strobe !== 1'b0 || show_valid !== 1'b0 || show_frame !== '0 || release_strobe !== 1'b0 || release_frame !== '0 || frame_cnt !== '0) begin bad++; $display("FAIL midreset_outputs: got st=%b v=%b sf=%h rs=%b rf=%h fc=%0d want all 0", fifo_strobe, show_valid, show_frame, release_strobe, release_frame, frame_cnt); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (n_rel != r0) begin bad++; $display("FAIL midreset_no_release: got %0d releases want 0", n_rel - r0); end
        pulse_vsync(1'b0);
        total++; if (o_show2 !== mk(8'hA4) || o_valid2 !== 1'b1 || o_nstrobe != 1 || o_nrel != 0) begin bad++; $display("FAIL midreset_repop: got %h v=%b st=%0d rel=%0d want %h 1 1 0", o_show2, o_valid2, o_nstrobe, o_nrel, mk(8'hA4)); end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat_count = 4'd1;
        push(mk(8'hA5));
        repeat (2) @(negedge clk);
        pulse_vsync(1'b0);
        for (int i = 0; i < (1 << CW) - 1; i++) pulse_vsync(1'b0);
        total++; if (underrun_cnt !== '1) begin bad++; $display("FAIL sat_reach: got %0d want %0d", underrun_cnt, (1 << CW) - 1); end
        for (int i = 0; i < 6; i++) pulse_vsync(1'b0);
        total++; if (underrun_cnt !== '1) begin bad++; $display("FAIL sat_hold: got %0d want %0d", underrun_cnt, (1 << CW) - 1); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_underrun();
        test_repeat_zero();
        test_flush();
        test_reset_mid_pop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
